// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and scan-code helpers for the keyboard controller.
package kbd_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  // True for either shift key's scan code.
  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/kbd_ctrl_if.sv
// Bundles the PS2_host frame handshake and the LC-3 memory bus of kbd_ctrl.
interface kbd_ctrl_if;
  logic        cmd_rdy;
  logic [8:0]  cmd;
  logic        error;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    output cmd_rdy, cmd, error, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  cmd_rdy, cmd, error, mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/kbd_ctrl_scan2ascii.sv
// scan2ascii: combinational scan code set 2 (make code) to ASCII lookup.
// Letters honour shift as upper case, digits give their US-layout shifted symbol.
module scan2ascii (
  input  logic [7:0] scan,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [7:0] base;
  logic [7:0] alt;

  // Table lookup: base character, shifted character and a mapped flag.
  always_comb begin
    valid = 1'b0;
    base  = 8'h00;
    alt   = 8'h00;
    case (scan)
      8'h1C: {valid, base, alt} = {1'b1, 8'h61, 8'h41};
      8'h32: {valid, base, alt} = {1'b1, 8'h62, 8'h42};
      8'h21: {valid, base, alt} = {1'b1, 8'h63, 8'h43};
      8'h23: {valid, base, alt} = {1'b1, 8'h64, 8'h44};
      8'h24: {valid, base, alt} = {1'b1, 8'h65, 8'h45};
      8'h2B: {valid, base, alt} = {1'b1, 8'h66, 8'h46};
      8'h34: {valid, base, alt} = {1'b1, 8'h67, 8'h47};
      8'h33: {valid, base, alt} = {1'b1, 8'h68, 8'h48};
      8'h43: {valid, base, alt} = {1'b1, 8'h69, 8'h49};
      8'h3B: {valid, base, alt} = {1'b1, 8'h6A, 8'h4A};
      8'h42: {valid, base, alt} = {1'b1, 8'h6B, 8'h4B};
      8'h4B: {valid, base, alt} = {1'b1, 8'h6C, 8'h4C};
      8'h3A: {valid, base, alt} = {1'b1, 8'h6D, 8'h4D};
      8'h31: {valid, base, alt} = {1'b1, 8'h6E, 8'h4E};
      8'h44: {valid, base, alt} = {1'b1, 8'h6F, 8'h4F};
      8'h4D: {valid, base, alt} = {1'b1, 8'h70, 8'h50};
      8'h15: {valid, base, alt} = {1'b1, 8'h71, 8'h51};
      8'h2D: {valid, base, alt} = {1'b1, 8'h72, 8'h52};
      8'h1B: {valid, base, alt} = {1'b1, 8'h73, 8'h53};
      8'h2C: {valid, base, alt} = {1'b1, 8'h74, 8'h54};
      8'h3C: {valid, base, alt} = {1'b1, 8'h75, 8'h55};
      8'h2A: {valid, base, alt} = {1'b1, 8'h76, 8'h56};
      8'h1D: {valid, base, alt} = {1'b1, 8'h77, 8'h57};
      8'h22: {valid, base, alt} = {1'b1, 8'h78, 8'h58};
      8'h35: {valid, base, alt} = {1'b1, 8'h79, 8'h59};
      8'h1A: {valid, base, alt} = {1'b1, 8'h7A, 8'h5A};
      8'h16: {valid, base, alt} = {1'b1, 8'h31, 8'h21};
      8'h1E: {valid, base, alt} = {1'b1, 8'h32, 8'h40};
      8'h26: {valid, base, alt} = {1'b1, 8'h33, 8'h23};
      8'h25: {valid, base, alt} = {1'b1, 8'h34, 8'h24};
      8'h2E: {valid, base, alt} = {1'b1, 8'h35, 8'h25};
      8'h36: {valid, base, alt} = {1'b1, 8'h36, 8'h5E};
      8'h3D: {valid, base, alt} = {1'b1, 8'h37, 8'h26};
      8'h3E: {valid, base, alt} = {1'b1, 8'h38, 8'h2A};
      8'h46: {valid, base, alt} = {1'b1, 8'h39, 8'h28};
      8'h45: {valid, base, alt} = {1'b1, 8'h30, 8'h29};
      8'h29: {valid, base, alt} = {1'b1, 8'h20, 8'h20};
      8'h5A: {valid, base, alt} = {1'b1, 8'h0A, 8'h0A};
      8'h66: {valid, base, alt} = {1'b1, 8'h08, 8'h08};
      default: {valid, base, alt} = {1'b0, 8'h00, 8'h00};
    endcase
  end

  assign ascii = shift ? alt : base;

endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 scan-code decoder, shift tracking, character FIFO and LC-3
// KBSR/KBDR registers. Optional feature macro: KBD_IRQ_EN (writable IE bit and
// a registered kbd_irq = IE & ready); without it IE reads 0 and kbd_irq is 0.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  kbd_ctrl_if.slave     bus,
  output logic          kbd_irq
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  kbd_state_t state, next_state;
  logic       shift, next_shift;
  logic [7:0] code;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       push_req;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          ovr;
  logic          ie;
  logic [15:0]   rdata;

  logic ready, full, rd_kbsr, rd_kbdr, pop, do_push, ovr_set;

  assign code = bus.cmd[7:0];

  scan2ascii u_scan2ascii (
    .scan  (code),
    .shift (shift),
    .ascii (ascii),
    .valid (ascii_valid)
  );

  // Decoder state and shift flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= 1'b0;
    end else begin
      state <= next_state;
      shift <= next_shift;
    end
  end

  // Make/break/extended sequence decoding; error aborts any partial sequence.
  always_comb begin
    next_state = state;
    next_shift = shift;
    push_req   = 1'b0;
    if (bus.error) begin
      next_state = IDLE;
    end else if (bus.cmd_rdy) begin
      case (state)
        IDLE: begin
          if (code == SC_EXT) begin
            next_state = EXT;
          end else if (code == SC_BRK) begin
            next_state = BRK;
          end else if (is_shift_code(code)) begin
            next_shift = 1'b1;
          end else begin
            push_req = ascii_valid;
          end
        end
        BRK: begin
          next_state = IDLE;
          if (is_shift_code(code)) begin
            next_shift = 1'b0;
          end else begin
            next_shift = shift;
          end
        end
        EXT: begin
          if (code == SC_BRK) begin
            next_state = EXT_BRK;
          end else begin
            next_state = IDLE;
          end
        end
        EXT_BRK: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end else begin
      next_state = state;
    end
  end

  // Bus decode and FIFO push/pop/overrun qualification.
  always_comb begin
    ready   = (count != {(PW+1){1'b0}});
    full    = (count == FULL_CNT);
    rd_kbsr = bus.mem_rd & (bus.mem_addr == KBSR_ADDR);
    rd_kbdr = bus.mem_rd & (bus.mem_addr == KBDR_ADDR);
    pop     = rd_kbdr & ready;
    do_push = push_req & (~full | pop);
    ovr_set = push_req & full & ~pop;
  end

  // FIFO pointers, occupancy and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {(PW+1){1'b0}};
      ovr    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // A new overrun in the same cycle as a status read must not be lost.
      if (ovr_set)      ovr <= 1'b1;
      else if (rd_kbsr) ovr <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ascii;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 16'h0000;
    end else if (bus.mem_rd) begin
      if (rd_kbsr)      rdata <= {ready, ie, ovr, 13'h0000};
      else if (pop)     rdata <= {8'h00, mem[rd_ptr]};
      else              rdata <= 16'h0000;
    end
  end

  assign bus.mem_rdata = rdata;

`ifdef KBD_IRQ_EN
  logic wr_kbsr;
  logic unused_bits;
  assign wr_kbsr     = bus.mem_wr & ~bus.mem_rd & (bus.mem_addr == KBSR_ADDR);
  assign unused_bits = ^{bus.mem_wdata[15], bus.mem_wdata[13:0], bus.cmd[8]};

  // Interrupt enable register and registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie      <= 1'b0;
      kbd_irq <= 1'b0;
    end else begin
      if (wr_kbsr) ie <= bus.mem_wdata[14];
      kbd_irq <= ie & ready;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{bus.mem_wr, bus.mem_wdata, bus.cmd[8]};
  assign ie      = 1'b0;
  assign kbd_irq = 1'b0;
`endif

endmodule
